// File: rtl/msi_irq_ctrl_pkg.sv
// Shared definitions for the MSI interrupt controller: FSM states,
// the fixed MSI vector and width helpers.
package pcie_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_HOLD = 2'd2
  } irq_state_t;

  localparam logic [7:0] MSI_VEC_RXTX = 8'h00;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (value > (32'd1 << i)) result = i + 1;
    end
    return result;
  endfunction

  // Hold-off counter must hold COAL_CYCLES-1 and never collapse to zero bits.
  function automatic int unsigned holdoff_w(input int unsigned coal_cycles);
    int unsigned w;
    w = clog2(coal_cycles + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/msi_irq_ctrl_if.sv
// Endpoint CFG interrupt handshake between the controller (master)
// and the Virtex-5 PCIe endpoint (slave).
interface msi_irq_ctrl_if;

  logic       cfg_interrupt_msienable;
  logic       cfg_interrupt_rdy_n;
  logic       cfg_interrupt_n;
  logic       cfg_interrupt_assert_n;
  logic [7:0] cfg_interrupt_di;

  modport master (
    input  cfg_interrupt_msienable,
    input  cfg_interrupt_rdy_n,
    output cfg_interrupt_n,
    output cfg_interrupt_assert_n,
    output cfg_interrupt_di
  );

  modport slave (
    output cfg_interrupt_msienable,
    output cfg_interrupt_rdy_n,
    input  cfg_interrupt_n,
    input  cfg_interrupt_assert_n,
    input  cfg_interrupt_di
  );

endinterface

// File: rtl/msi_irq_ctrl_holdoff_tmr.sv
// Coalescing hold-off timer: loads COAL_CYCLES-1, counts down to zero
// and then rests there until the next load.
module irq_holdoff_tmr
  import pcie_irq_pkg::*;
#(
  parameter int unsigned COAL_CYCLES = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CW     = holdoff_w(COAL_CYCLES);
  localparam int unsigned LOAD_V = (COAL_CYCLES > 0) ? COAL_CYCLES - 1 : 0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LOAD_V);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/msi_irq_ctrl.sv
// Merges RX/TX interrupt requests into sticky pending flags and issues
// single-vector MSIs through the endpoint handshake, spaced by a hold-off window.
module msi_irq_ctrl
  import pcie_irq_pkg::*;
#(
  parameter int unsigned COAL_CYCLES = 250,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_send_irq,
  input  logic               tx_send_irq,
  msi_irq_ctrl_if.master     cfg,
  output logic [1:0]         irq_pending,
  output logic [CNT_W-1:0]   irq_served_cnt
);

  irq_state_t state;
  irq_state_t state_next;
  logic       req_n;
  logic       complete;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;
  logic [1:0] src;

  assign src      = {tx_send_irq, rx_send_irq};
  assign complete = !req_n && !cfg.cfg_interrupt_rdy_n;

  irq_holdoff_tmr #(
    .COAL_CYCLES(COAL_CYCLES)
  ) u_holdoff (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (cfg.cfg_interrupt_msienable && (irq_pending != 2'b00)) begin
          state_next = IRQ_REQ;
        end
      end
      // Once raised, the request is held until accepted, even if MSI is disabled.
      IRQ_REQ: begin
        if (complete) begin
          if (COAL_CYCLES == 0) begin
            state_next = IRQ_IDLE;
          end else begin
            state_next = IRQ_HOLD;
            tmr_load   = 1'b1;
          end
        end
      end
      IRQ_HOLD: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_next = IRQ_IDLE;
      end
      default: state_next = IRQ_IDLE;
    endcase
  end

  // A source pulse coinciding with completion re-arms its flag for a further MSI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IRQ_IDLE;
      req_n          <= 1'b1;
      irq_pending    <= 2'b00;
      irq_served_cnt <= '0;
    end else begin
      state       <= state_next;
      req_n       <= (state_next != IRQ_REQ);
      irq_pending <= (irq_pending & {2{~complete}}) | src;
      if (complete) irq_served_cnt <= irq_served_cnt + CNT_W'(1);
    end
  end

  assign cfg.cfg_interrupt_n        = req_n;
  assign cfg.cfg_interrupt_assert_n = 1'b1;
  assign cfg.cfg_interrupt_di       = MSI_VEC_RXTX;

endmodule

// File: tb/tb_msi_irq_ctrl.sv
// Randomized and directed bench for msi_irq_ctrl, checked every cycle
// against a timestamp-based reference model of the interrupt rules.
module tb_msi_irq_ctrl;

  localparam int unsigned COAL  = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx_send_irq;
  logic             tx_send_irq;
  logic [1:0]       irq_pending;
  logic [CNT_W-1:0] irq_served_cnt;

  msi_irq_ctrl_if cfg_if ();

  msi_irq_ctrl #(
    .COAL_CYCLES(COAL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_send_irq   (rx_send_irq),
    .tx_send_irq   (tx_send_irq),
    .cfg           (cfg_if),
    .irq_pending   (irq_pending),
    .irq_served_cnt(irq_served_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending flags, whether a request is outstanding, served
  // count and the earliest cycle a new request may appear after a completion.
  logic [1:0]  m_pend = 2'b00;
  logic        m_req  = 1'b0;
  int unsigned m_cnt  = 0;
  longint      m_earliest = 0;
  longint      cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelUpdate();
    logic       done;
    logic [1:0] old_pend;
    if (!rst_n) begin
      m_pend     = 2'b00;
      m_req      = 1'b0;
      m_cnt      = 0;
      m_earliest = 0;
    end else begin
      done     = m_req && !cfg_if.cfg_interrupt_rdy_n;
      old_pend = m_pend;
      if (done) begin
        m_pend     = {tx_send_irq, rx_send_irq};
        m_cnt      = (m_cnt + 1) % (1 << CNT_W);
        m_req      = 1'b0;
        m_earliest = cyc + COAL + 2;
      end else begin
        m_pend = old_pend | {tx_send_irq, rx_send_irq};
        if (!m_req && cfg_if.cfg_interrupt_msienable && (old_pend != 2'b00) &&
            (cyc + 1 >= m_earliest)) begin
          m_req = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rx, input logic tx, input logic en,
                               input logic rdy_n, input logic rs_n);
    rx_send_irq                    = rx;
    tx_send_irq                    = tx;
    cfg_if.cfg_interrupt_msienable = en;
    cfg_if.cfg_interrupt_rdy_n     = rdy_n;
    rst_n                          = rs_n;
    @(posedge clk);
    modelUpdate();
    cyc++;
    @(negedge clk);
    checkOutput("cfg_interrupt_n", {31'b0, cfg_if.cfg_interrupt_n}, {31'b0, !m_req});
    checkOutput("irq_pending", {30'b0, irq_pending}, {30'b0, m_pend});
    checkOutput("irq_served_cnt", {28'b0, irq_served_cnt}, m_cnt);
    checkOutput("assert_n", {31'b0, cfg_if.cfg_interrupt_assert_n}, 32'd1);
    checkOutput("di", {24'b0, cfg_if.cfg_interrupt_di}, 32'h00);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, en, 1'b1, 1'b1);
  endtask

  task automatic waitReq(input int budget);
    int n;
    n = 0;
    while ((cfg_if.cfg_interrupt_n !== 1'b0) && (n < budget)) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      n++;
    end
    checkOutput("wait_req", {31'b0, cfg_if.cfg_interrupt_n}, 32'd0);
  endtask

  initial begin
    int first_low;
    rst_n                          = 1'b0;
    rx_send_irq                    = 1'b0;
    tx_send_irq                    = 1'b0;
    cfg_if.cfg_interrupt_msienable = 1'b0;
    cfg_if.cfg_interrupt_rdy_n     = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("reset_cfg_n", {31'b0, cfg_if.cfg_interrupt_n}, 32'd1);
    checkOutput("reset_pending", {30'b0, irq_pending}, 32'd0);
    checkOutput("reset_cnt", {28'b0, irq_served_cnt}, 32'd0);

    $display("[TB] single rx interrupt");
    idle(5, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t1_pend_set", {30'b0, irq_pending}, 32'd1);
    checkOutput("t1_not_yet", {31'b0, cfg_if.cfg_interrupt_n}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t1_req_low", {31'b0, cfg_if.cfg_interrupt_n}, 32'd0);
    idle(2, 1'b1);
    checkOutput("t1_still_low", {31'b0, cfg_if.cfg_interrupt_n}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t1_released", {31'b0, cfg_if.cfg_interrupt_n}, 32'd1);
    checkOutput("t1_pend_clr", {30'b0, irq_pending}, 32'd0);
    checkOutput("t1_cnt", {28'b0, irq_served_cnt}, 32'd1);
    idle(8, 1'b1);

    $display("[TB] coalescing window");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    waitReq(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    first_low = -1;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, (k == 1), 1'b1, 1'b0, 1'b1);
      if ((first_low < 0) && (cfg_if.cfg_interrupt_n === 1'b0)) first_low = k + 1;
    end
    checkOutput("t2_gap_ok", {31'b0, (first_low >= 6)}, 32'd1);
    checkOutput("t2_cnt", {28'b0, irq_served_cnt}, 32'd3);
    idle(8, 1'b1);

    $display("[TB] merged sources");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(1, 1'b1);
    end
    checkOutput("t3_pend_both", {30'b0, irq_pending}, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_pend_clr", {30'b0, irq_pending}, 32'd0);
    checkOutput("t3_cnt", {28'b0, irq_served_cnt}, 32'd4);
    idle(12, 1'b1);
    checkOutput("t3_single", {28'b0, irq_served_cnt}, 32'd4);

    $display("[TB] pulse on completion cycle");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    waitReq(10);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_pend_kept", {30'b0, irq_pending}, 32'd1);
    waitReq(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_cnt", {28'b0, irq_served_cnt}, 32'd6);
    idle(8, 1'b1);

    $display("[TB] msienable gating");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(100, 1'b0);
    checkOutput("t5_held_pend", {30'b0, irq_pending}, 32'd1);
    checkOutput("t5_no_req", {31'b0, cfg_if.cfg_interrupt_n}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t5_req_after_en", {31'b0, cfg_if.cfg_interrupt_n}, 32'd0);
    idle(5, 1'b0);
    checkOutput("t5_req_held", {31'b0, cfg_if.cfg_interrupt_n}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_done", {31'b0, cfg_if.cfg_interrupt_n}, 32'd1);
    idle(8, 1'b1);

    $display("[TB] reset mid-handshake");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    waitReq(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_cfg_n", {31'b0, cfg_if.cfg_interrupt_n}, 32'd1);
    checkOutput("t6_pend", {30'b0, irq_pending}, 32'd0);
    checkOutput("t6_cnt", {28'b0, irq_served_cnt}, 32'd0);
    idle(20, 1'b1);
    checkOutput("t6_no_spurious", {31'b0, cfg_if.cfg_interrupt_n}, 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 19) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 599) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
